wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 129 ++++++++++++
 tb/tb_wb_regfile.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MEM/WB pipeline register, load-data extension, 32x32 register file with
// write-through read ports, and a retired-instruction counter.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_wen,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic        mem_memtoreg,
  input  logic [2:0]  mem_ld_type,
  input  logic [1:0]  mem_byte_off,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [4:0]  W,
  output logic [31:0] final_data,
  output logic [31:0] retired
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] mem_result;
  logic        capture_wr;

  logic        valid_reg, valid_next;
  logic [4:0]  w_reg, w_next;
  logic [31:0] data_reg, data_next;
  logic [31:0] retired_reg, retired_next;

  logic [31:0] regs [32];

  // Little-endian lane select; halfword ignores byte_off[0].
  always_comb begin
    load_byte = 8'h00;
    case (mem_byte_off)
      2'd0:    load_byte = mem_load_data[7:0];
      2'd1:    load_byte = mem_load_data[15:8];
      2'd2:    load_byte = mem_load_data[23:16];
      default: load_byte = mem_load_data[31:24];
    endcase
    load_half = mem_byte_off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
  end

  always_comb begin
    load_ext = mem_load_data;
    case (mem_ld_type)
      LD_LW:   load_ext = mem_load_data;
      LD_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
      LD_LBU:  load_ext = {24'h000000, load_byte};
      LD_LH:   load_ext = {{16{load_half[15]}}, load_half};
      LD_LHU:  load_ext = {16'h0000, load_half};
      default: load_ext = mem_load_data;
    endcase
    mem_result = mem_memtoreg ? load_ext : mem_alu_result;
  end

  // Non-writing entries carry W=0/data=0 so forwarding on $0 always sees zero.
  assign capture_wr = mem_valid && mem_wen && (mem_waddr != 5'd0);

  always_comb begin
    valid_next = valid_reg;
    w_next     = w_reg;
    data_next  = data_reg;
    if (flush) begin
      valid_next = 1'b0;
      w_next     = 5'd0;
      data_next  = 32'd0;
    end else if (!stall) begin
      valid_next = mem_valid;
      w_next     = capture_wr ? mem_waddr : 5'd0;
      data_next  = capture_wr ? mem_result : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      w_reg     <= 5'd0;
      data_reg  <= 32'd0;
    end else begin
      valid_reg <= valid_next;
      w_reg     <= w_next;
      data_reg  <= data_next;
    end
  end

  assign retired_next = retired_reg + {31'd0, (valid_reg && !stall)};

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= 32'd0;
    end else begin
      retired_reg <= retired_next;
    end
  end

  // Held WB entries simply rewrite the same value each stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (w_reg != 5'd0) begin
      regs[w_reg] <= data_reg;
    end
  end

  assign rs_data = (rs_addr == 5'd0)  ? 32'd0    :
                   (rs_addr == w_reg) ? data_reg : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0)  ? 32'd0    :
                   (rt_addr == w_reg) ? data_reg : regs[rt_addr];

  assign W          = w_reg;
  assign final_data = data_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: write-back, load extension,
// $0 handling, stall/flush, mid-stream reset and retired-counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic        mem_memtoreg;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_byte_off;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  W;
  logic [31:0] final_data;
  logic [31:0] retired;

  int vectors;
  int miscompares;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_wen        (mem_wen),
    .mem_waddr      (mem_waddr),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_memtoreg   (mem_memtoreg),
    .mem_ld_type    (mem_ld_type),
    .mem_byte_off   (mem_byte_off),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .W              (W),
    .final_data     (final_data),
    .retired        (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid      = 1'b0;
    mem_wen        = 1'b0;
    mem_waddr      = 5'd0;
    mem_alu_result = 32'd0;
    mem_load_data  = 32'd0;
    mem_memtoreg   = 1'b0;
    mem_ld_type    = 3'd0;
    mem_byte_off   = 2'd0;
  endtask

  task automatic drive_alu(input logic [4:0] addr, input logic [31:0] val, input logic wen);
    mem_valid      = 1'b1;
    mem_wen        = wen;
    mem_waddr      = addr;
    mem_alu_result = val;
    mem_memtoreg   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle_inputs();
    rs_addr = 5'd5; rt_addr = 5'd31;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (W !== 5'd0) begin miscompares++; $display("FAIL reset_W got %0d exp 0", W); end
    vectors++;
    if (final_data !== 32'd0) begin miscompares++; $display("FAIL reset_final got %h exp 0", final_data); end
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL reset_retired got %h exp 0", retired); end
    vectors++;
    if (rt_data !== 32'd0) begin miscompares++; $display("FAIL reset_r31 got %h exp 0", rt_data); end
    $display("reset done");
  endtask

  task automatic test_writeback();
    drive_alu(5'd5, 32'h0000_1234, 1'b1);
    step();
    idle_inputs();
    rs_addr = 5'd5;
    #1;
    vectors++;
    if (W !== 5'd5) begin miscompares++; $display("FAIL wb_W got %0d exp 5", W); end
    vectors++;
    if (final_data !== 32'h0000_1234) begin miscompares++; $display("FAIL wb_final got %h exp 00001234", final_data); end
    vectors++;
    if (rs_data !== 32'h0000_1234) begin miscompares++; $display("FAIL wb_writethrough got %h exp 00001234", rs_data); end
    step();
    vectors++;
    if (W !== 5'd0) begin miscompares++; $display("FAIL wb_W_after got %0d exp 0", W); end
    vectors++;
    if (rs_data !== 32'h0000_1234) begin miscompares++; $display("FAIL wb_array got %h exp 00001234", rs_data); end
    vectors++;
    if (retired !== 32'd1) begin miscompares++; $display("FAIL wb_retired got %0d exp 1", retired); end
    $display("writeback r5 = %h", rs_data);
  endtask

  task automatic test_loads();
    logic [2:0]  typ [9];
    logic [1:0]  off [9];
    logic [31:0] exp [9];
    typ[0] = 3'b001; off[0] = 2'd0; exp[0] = 32'h0000_0001;
    typ[1] = 3'b001; off[1] = 2'd1; exp[1] = 32'h0000_007F;
    typ[2] = 3'b001; off[2] = 2'd2; exp[2] = 32'hFFFF_FFFF;
    typ[3] = 3'b001; off[3] = 2'd3; exp[3] = 32'hFFFF_FF80;
    typ[4] = 3'b100; off[4] = 2'd2; exp[4] = 32'h0000_80FF;
    typ[5] = 3'b011; off[5] = 2'd3; exp[5] = 32'hFFFF_80FF;
    typ[6] = 3'b010; off[6] = 2'd3; exp[6] = 32'h0000_0080;
    typ[7] = 3'b000; off[7] = 2'd1; exp[7] = 32'h80FF_7F01;
    typ[8] = 3'b111; off[8] = 2'd2; exp[8] = 32'h80FF_7F01;
    for (int i = 0; i < 9; i++) begin
      mem_valid      = 1'b1;
      mem_wen        = 1'b1;
      mem_waddr      = 5'(16 + i);
      mem_alu_result = 32'hA5A5_A5A5;
      mem_load_data  = 32'h80FF_7F01;
      mem_memtoreg   = 1'b1;
      mem_ld_type    = typ[i];
      mem_byte_off   = off[i];
      step();
      $display("load type=%0d off=%0d result=%h", typ[i], off[i], final_data);
      vectors++;
      if (final_data !== exp[i]) begin
        miscompares++;
        $display("FAIL load_%0d got %h exp %h", i, final_data, exp[i]);
      end
    end
    idle_inputs();
    step();
    rt_addr = 5'd18;
    #1;
    vectors++;
    if (rt_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL load_array_r18 got %h exp ffffffff", rt_data); end
    vectors++;
    if (retired !== 32'd10) begin miscompares++; $display("FAIL load_retired got %0d exp 10", retired); end
  endtask

  task automatic test_reg0();
    drive_alu(5'd0, 32'h0000_DEAD, 1'b1);
    step();
    idle_inputs();
    rs_addr = 5'd0;
    #1;
    vectors++;
    if (W !== 5'd0) begin miscompares++; $display("FAIL r0_W got %0d exp 0", W); end
    vectors++;
    if (final_data !== 32'd0) begin miscompares++; $display("FAIL r0_final got %h exp 0", final_data); end
    vectors++;
    if (rs_data !== 32'd0) begin miscompares++; $display("FAIL r0_read got %h exp 0", rs_data); end
    step();
    vectors++;
    if (retired !== 32'd11) begin miscompares++; $display("FAIL r0_retired got %0d exp 11", retired); end
    $display("write to r0, retired=%0d", retired);
  endtask

  task automatic test_stall_flush();
    drive_alu(5'd12, 32'h0000_CAFE, 1'b1);
    step();
    drive_alu(5'd13, 32'h0000_BEEF, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (W !== 5'd12 || final_data !== 32'h0000_CAFE) begin
        miscompares++;
        $display("FAIL stall_hold_%0d got W=%0d data=%h exp W=12 data=0000cafe", i, W, final_data);
      end
      vectors++;
      if (retired !== 32'd11) begin miscompares++; $display("FAIL stall_retired_%0d got %0d exp 11", i, retired); end
    end
    flush = 1'b1;
    step();
    vectors++;
    if (W !== 5'd0 || final_data !== 32'd0) begin
      miscompares++;
      $display("FAIL stall_flush_bubble got W=%0d data=%h exp W=0 data=0", W, final_data);
    end
    vectors++;
    if (retired !== 32'd11) begin miscompares++; $display("FAIL stall_flush_retired got %0d exp 11", retired); end
    stall = 1'b0; flush = 1'b0;
    drive_alu(5'd14, 32'h1414_1414, 1'b1);
    step();
    drive_alu(5'd15, 32'h1515_1515, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_inputs();
    rs_addr = 5'd14; rt_addr = 5'd15;
    #1;
    vectors++;
    if (W !== 5'd0) begin miscompares++; $display("FAIL flush_W got %0d exp 0", W); end
    vectors++;
    if (retired !== 32'd12) begin miscompares++; $display("FAIL flush_retired got %0d exp 12", retired); end
    vectors++;
    if (rs_data !== 32'h1414_1414) begin miscompares++; $display("FAIL flush_r14 got %h exp 14141414", rs_data); end
    vectors++;
    if (rt_data !== 32'd0) begin miscompares++; $display("FAIL flush_r15 got %h exp 0", rt_data); end
    rs_addr = 5'd12; rt_addr = 5'd13;
    #1;
    vectors++;
    if (rs_data !== 32'h0000_CAFE) begin miscompares++; $display("FAIL stall_r12 got %h exp 0000cafe", rs_data); end
    vectors++;
    if (rt_data !== 32'd0) begin miscompares++; $display("FAIL stall_r13 got %h exp 0", rt_data); end
    $display("stall/flush sequence, retired=%0d", retired);
  endtask

  task automatic test_both_ports_same();
    drive_alu(5'd9, 32'h0909_0909, 1'b1);
    step();
    idle_inputs();
    rs_addr = 5'd9; rt_addr = 5'd9;
    #1;
    vectors++;
    if (rs_data !== 32'h0909_0909 || rt_data !== 32'h0909_0909) begin
      miscompares++;
      $display("FAIL dual_fwd got rs=%h rt=%h exp 09090909", rs_data, rt_data);
    end
    step();
    $display("dual port read r9 = %h", rs_data);
  endtask

  task automatic test_reset_midstream();
    drive_alu(5'd7, 32'h0000_0777, 1'b1);
    step();
    vectors++;
    if (W !== 5'd7) begin miscompares++; $display("FAIL rstmid_pending_W got %0d exp 7", W); end
    idle_inputs();
    rst = 1'b1; stall = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    rs_addr = 5'd7; rt_addr = 5'd5;
    #1;
    vectors++;
    if (W !== 5'd0 || final_data !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_wb got W=%0d data=%h exp W=0 data=0", W, final_data);
    end
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL rstmid_retired got %0d exp 0", retired); end
    vectors++;
    if (rs_data !== 32'd0) begin miscompares++; $display("FAIL rstmid_r7 got %h exp 0", rs_data); end
    vectors++;
    if (rt_data !== 32'd0) begin miscompares++; $display("FAIL rstmid_r5 got %h exp 0", rt_data); end
    $display("mid-stream reset done");
  endtask

  task automatic test_wrap();
    dut.retired_reg = 32'hFFFF_FFFF;
    drive_alu(5'd3, 32'h0000_0003, 1'b0);
    step();
    idle_inputs();
    vectors++;
    if (retired !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_pre got %h exp ffffffff", retired); end
    step();
    rs_addr = 5'd3;
    #1;
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL wrap got %h exp 0", retired); end
    vectors++;
    if (rs_data !== 32'd0) begin miscompares++; $display("FAIL wrap_nowrite_r3 got %h exp 0", rs_data); end
    $display("retired wrap -> %h", retired);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_writeback();
    test_loads();
    test_reg0();
    test_stall_flush();
    test_both_ports_same();
    test_reset_midstream();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
